// File: rtl/plic_pkg.sv
// Shared constants for the plic_gen2 interrupt controller: register offsets,
// the source-count ceiling and the claim-ID width helper.
package plic_pkg;
  localparam int MAX_SRC = 31;

  localparam logic [11:0] OFF_PENDING   = 12'h080;
  localparam logic [11:0] OFF_ENABLE    = 12'h100;
  localparam logic [11:0] OFF_EDGE      = 12'h104;
  localparam logic [11:0] OFF_THRESHOLD = 12'h200;
  localparam logic [11:0] OFF_CLAIM     = 12'h204;

  // Claim IDs run 0..n, so the field must hold n+1 distinct values.
  function automatic int claim_id_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: pending/in-flight tracking, pending follows the line by 1 cycle, no backpressure.
// PLIC_EDGE_TRIG_EN adds rising-edge mode with a deferred flag for edges seen while in flight.
module plic_gateway (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  input  logic edge_mode_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic inflight_o
);
  logic pending_q, pending_d;
  logic inflight_q, inflight_d;

`ifdef PLIC_EDGE_TRIG_EN
  logic line_prev_q;
  logic deferred_q, deferred_d;
  logic rise;
  assign rise = line_i & ~line_prev_q;
`else
  logic unused_edge_mode;
  assign unused_edge_mode = edge_mode_i;
`endif

  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
`ifdef PLIC_EDGE_TRIG_EN
    deferred_d = deferred_q;
`endif
    if (claim_i) begin
      pending_d  = 1'b0;
      inflight_d = 1'b1;
    end else if (complete_i) begin
      inflight_d = 1'b0;
    end
`ifdef PLIC_EDGE_TRIG_EN
    if (edge_mode_i) begin
      if (deferred_q && !inflight_q && !claim_i) begin
        pending_d  = 1'b1;
        deferred_d = 1'b0;
      end
      // An edge landing on the claim cycle belongs to the next service round.
      if (rise) begin
        if (inflight_q || claim_i) deferred_d = 1'b1;
        else                       pending_d  = 1'b1;
      end
    end else begin
      deferred_d = 1'b0;
      if (line_i && !inflight_q && !pending_q && !claim_i) pending_d = 1'b1;
    end
`else
    if (line_i && !inflight_q && !pending_q && !claim_i) pending_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
      deferred_q  <= 1'b0;
      line_prev_q <= 1'b0;
`endif
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
`ifdef PLIC_EDGE_TRIG_EN
      deferred_q  <= deferred_d;
      line_prev_q <= line_i;
`endif
    end
  end

  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;
endmodule

// File: rtl/plic_gen2.sv
// Parametrised PLIC core: register file, max-priority arbiter, claim/complete; 1-cycle reads, no backpressure.
// PLIC_EDGE_TRIG_EN enables the EDGE register and per-source rising-edge gateways.
module plic_gen2
  import plic_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int PRIO_BITS = 3,
  parameter int ADDR_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               irq_o
);
  localparam int ID_W = claim_id_w(NUM_SRC);

  logic [11:0] off;
  logic        rd_ok;
  logic        unused_bus;
  assign off        = addr[11:0];
  assign rd_ok      = rd_en && !wr_en;
  assign unused_bus = ^{addr, wr_data};

  logic [PRIO_BITS-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_BITS-1:0] prio_d [1:NUM_SRC];
  logic [NUM_SRC:1]     enable_q, enable_d;
  logic [PRIO_BITS-1:0] threshold_q, threshold_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 irq_q, irq_d;
  logic [31:0]          rd_val;

  logic [NUM_SRC:1] pending, inflight, claim_vec, complete_vec, edge_mode;
  logic [ID_W-1:0]      best_id;
  logic [PRIO_BITS-1:0] best_prio;

`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC:1] edge_q, edge_d;
  assign edge_mode = edge_q;
`else
  assign edge_mode = '0;
`endif

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .line_i      (irq_src_i[g-1]),
      .edge_mode_i (edge_mode[g]),
      .claim_i     (claim_vec[g]),
      .complete_i  (complete_vec[g]),
      .pending_o   (pending[g]),
      .inflight_o  (inflight[g])
    );
  end

  // Strict '>' keeps the lowest ID on equal priority; priority 0 never wins.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int s = 1; s <= NUM_SRC; s++) begin
      if (pending[s] && enable_q[s] && (prio_q[s] > best_prio)) begin
        best_prio = prio_q[s];
        best_id   = ID_W'(s);
      end
    end
  end

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int s = 1; s <= NUM_SRC; s++) begin
      claim_vec[s]    = rd_ok && (off == OFF_CLAIM) && (best_id == ID_W'(s));
      complete_vec[s] = wr_en && (off == OFF_CLAIM) && (wr_data == 32'(s)) && inflight[s];
    end
  end

  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
`ifdef PLIC_EDGE_TRIG_EN
    edge_d      = edge_q;
`endif
    if (wr_en && (off[1:0] == 2'b00)) begin
      if (off[11:7] == 5'd0) begin
        for (int s = 1; s <= NUM_SRC; s++)
          if (off[6:2] == 5'(s)) prio_d[s] = wr_data[PRIO_BITS-1:0];
      end else begin
        case (off)
          OFF_ENABLE:    enable_d    = wr_data[NUM_SRC:1];
`ifdef PLIC_EDGE_TRIG_EN
          OFF_EDGE:      edge_d      = wr_data[NUM_SRC:1];
`endif
          OFF_THRESHOLD: threshold_d = wr_data[PRIO_BITS-1:0];
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (off[1:0] == 2'b00) begin
      if (off[11:7] == 5'd0) begin
        for (int s = 1; s <= NUM_SRC; s++)
          if (off[6:2] == 5'(s)) rd_val = 32'(prio_q[s]);
      end else begin
        case (off)
          OFF_PENDING:   rd_val = 32'({pending, 1'b0});
          OFF_ENABLE:    rd_val = 32'({enable_q, 1'b0});
`ifdef PLIC_EDGE_TRIG_EN
          OFF_EDGE:      rd_val = 32'({edge_q, 1'b0});
`endif
          OFF_THRESHOLD: rd_val = 32'(threshold_q);
          OFF_CLAIM:     rd_val = 32'(best_id);
          default:       rd_val = '0;
        endcase
      end
    end
    // A read colliding with a write is dropped but still returns a defined 0.
    rd_data_d = rd_data_q;
    if (rd_ok)      rd_data_d = rd_val;
    else if (rd_en) rd_data_d = '0;
    irq_d = best_prio > threshold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 1; s <= NUM_SRC; s++) prio_q[s] <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
      rd_data_q   <= '0;
      irq_q       <= 1'b0;
`ifdef PLIC_EDGE_TRIG_EN
      edge_q      <= '0;
`endif
    end else begin
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
`ifdef PLIC_EDGE_TRIG_EN
      edge_q      <= edge_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign irq_o   = irq_q;
endmodule

// File: tb/tb_plic_gen2.sv
// Self-checking bench for plic_gen2 (NUM_SRC=8): register table, directed sequences, randomized model check.
module tb_plic_gen2;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  irq_src_i = '0;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        irq_o;

  int n_cmp  = 0;
  int n_fail = 0;

  plic_gen2 #(.NUM_SRC(8), .PRIO_BITS(3), .ADDR_W(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_src_i (irq_src_i),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    irq_src_i = '0; wr_en = 1'b0; rd_en = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_vec_t;

  // Behavioural model state for the randomized phase
  bit [8:1] m_pend, m_infl, m_en;
  int       m_prio [1:8];
  int       m_thr;
  bit [7:0] m_line;

  // Highest qualifying priority first, then the lowest ID carrying it.
  function automatic int model_claim();
    int maxp = 0;
    for (int s = 1; s <= 8; s++)
      if (m_pend[s] && m_en[s] && m_prio[s] > maxp) maxp = m_prio[s];
    if (maxp == 0) return 0;
    for (int s = 1; s <= 8; s++)
      if (m_pend[s] && m_en[s] && m_prio[s] == maxp) return s;
    return 0;
  endfunction

  function automatic bit model_irq();
    int maxp = 0;
    for (int s = 1; s <= 8; s++)
      if (m_pend[s] && m_en[s] && m_prio[s] > maxp) maxp = m_prio[s];
    return maxp > m_thr;
  endfunction

  initial begin
    reg_vec_t    regtab [10];
    logic [31:0] reset_addrs [9];
    logic [31:0] d;
    logic [31:0] v;

    reset_addrs = '{32'h000, 32'h004, 32'h01C, 32'h020, 32'h080,
                    32'h100, 32'h104, 32'h200, 32'h204};
    regtab[0] = '{32'h004, 32'h7,        32'h7};
    regtab[1] = '{32'h00C, 32'hFF,       32'h7};
    regtab[2] = '{32'h020, 32'h3,        32'h3};
    regtab[3] = '{32'h024, 32'h5,        32'h0};
    regtab[4] = '{32'h000, 32'hF,        32'h0};
    regtab[5] = '{32'h100, 32'hFFFFFFFF, 32'h1FE};
    regtab[6] = '{32'h200, 32'h1D,       32'h5};
    regtab[7] = '{32'h10000200, 32'h2,   32'h2};
    regtab[8] = '{32'h300, 32'h1234,     32'h0};
`ifdef PLIC_EDGE_TRIG_EN
    regtab[9] = '{32'h104, 32'hFFFFFFFF, 32'h1FE};
`else
    regtab[9] = '{32'h104, 32'hFFFFFFFF, 32'h0};
`endif

    do_reset();
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    foreach (reset_addrs[i]) rd_check($sformatf("reset_read_%03h", reset_addrs[i]), reset_addrs[i], 32'd0);
    check("reset_irq_after_reads", {31'd0, irq_o}, 32'd0);

    foreach (regtab[i]) begin
      wr(regtab[i].a, regtab[i].d);
      rd_check($sformatf("regtab_%0d", i), regtab[i].a, regtab[i].exp);
    end

    // Single source: raise, claim, complete with the line still high
    do_reset();
    wr(32'h00C, 2); wr(32'h100, 32'h08); wr(32'h200, 1);
    irq_src_i[2] = 1'b1;
    tick();
    check("a_irq_after_1", {31'd0, irq_o}, 32'd0);
    tick();
    check("a_irq_after_2", {31'd0, irq_o}, 32'd1);
    rd_check("a_claim", 32'h204, 32'd3);
    tick();
    check("a_irq_cleared", {31'd0, irq_o}, 32'd0);
    rd_check("a_pending_inflight", 32'h080, 32'd0);
    wr(32'h204, 3);
    tick();
    rd_check("a_repend", 32'h080, 32'h08);
    check("a_irq_repend", {31'd0, irq_o}, 32'd1);

    // Priority ordering and threshold
    do_reset();
    wr(32'h008, 5); wr(32'h014, 5); wr(32'h018, 4); wr(32'h100, 32'h64);
    irq_src_i = 8'h32;
    tick(); tick();
    irq_src_i = 8'h00;
    wr(32'h200, 5);
    tick();
    check("b_thr5_irq", {31'd0, irq_o}, 32'd0);
    wr(32'h200, 4);
    tick();
    check("b_thr4_irq", {31'd0, irq_o}, 32'd1);
    rd_check("b_claim_1", 32'h204, 32'd2);
    rd_check("b_claim_2", 32'h204, 32'd5);
    rd_check("b_claim_3", 32'h204, 32'd6);
    rd_check("b_claim_4", 32'h204, 32'd0);

    // Bogus completes must leave in-flight state alone
    wr(32'h01C, 1);
    irq_src_i = 8'h42;
    tick(); tick();
    wr(32'h204, 7); wr(32'h204, 0); wr(32'h204, 40); wr(32'h204, 34);
    tick(); tick();
    rd_check("c_bad_completes", 32'h080, 32'h80);
    wr(32'h204, 2);
    tick();
    rd_check("c_good_complete", 32'h080, 32'h84);

    // Simultaneous write and read
    addr = 32'h200; wr_data = 3; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("c_wrrd_rd_data", rd_data, 32'd0);
    rd_check("c_wrrd_written", 32'h200, 32'd3);
    addr = 32'h204; wr_data = 0; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("c_wrrd_claim_rd", rd_data, 32'd0);
    rd_check("c_wrrd_no_claim", 32'h080, 32'h84);

    // Reset with an access in the same cycle
    irq_src_i = '0;
    rst_i = 1'b1; addr = 32'h100; wr_data = 32'hFF; wr_en = 1'b1;
    tick();
    rst_i = 1'b0; wr_en = 1'b0;
    tick();
    rd_check("r_enable_cleared", 32'h100, 32'd0);
    rd_check("r_pending_cleared", 32'h080, 32'd0);
    rd_check("r_threshold_cleared", 32'h200, 32'd0);
    check("r_irq_cleared", {31'd0, irq_o}, 32'd0);

`ifdef PLIC_EDGE_TRIG_EN
    do_reset();
    wr(32'h010, 1); wr(32'h100, 32'h10); wr(32'h104, 32'h10);
    for (int p = 0; p < 2; p++) begin
      irq_src_i[3] = 1'b1; tick(); irq_src_i[3] = 1'b0; tick();
    end
    rd_check("e_pending", 32'h080, 32'h10);
    rd_check("e_claim", 32'h204, 32'd4);
    rd_check("e_coalesced", 32'h204, 32'd0);
    irq_src_i[3] = 1'b1; tick(); irq_src_i[3] = 1'b0; tick();
    rd_check("e_deferred_not_pending", 32'h080, 32'd0);
    wr(32'h204, 4);
    tick();
    rd_check("e_deferred_pends", 32'h080, 32'h10);
    rd_check("e_reclaim", 32'h204, 32'd4);
`endif

    // Randomized operations against the behavioural model
    do_reset();
    m_pend = '0; m_infl = '0; m_en = '0; m_thr = 0; m_line = '0;
    for (int s = 1; s <= 8; s++) m_prio[s] = 0;
    for (int it = 0; it < 300; it++) begin
      int op;
      int s;
      int id;
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          m_line = 8'($urandom);
          irq_src_i = m_line;
          tick();
        end
        1: begin
          s = $urandom_range(1, 8);
          m_prio[s] = $urandom_range(0, 7);
          wr(32'(4 * s), 32'(m_prio[s]));
        end
        2: begin
          v = $urandom;
          m_en = v[8:1];
          wr(32'h100, v);
        end
        3: begin
          m_thr = $urandom_range(0, 7);
          wr(32'h200, 32'(m_thr));
        end
        4: begin
          id = model_claim();
          rd(32'h204, d);
          check($sformatf("rand_claim_%0d", it), d, 32'(id));
          if (id != 0) begin
            m_pend[id] = 1'b0;
            m_infl[id] = 1'b1;
          end
        end
        default: begin
          id = $urandom_range(0, 10);
          wr(32'h204, 32'(id));
          if (id >= 1 && id <= 8 && m_infl[id]) m_infl[id] = 1'b0;
        end
      endcase
      tick(); tick(); tick();
      for (int k = 1; k <= 8; k++)
        if (m_line[k-1] && !m_infl[k]) m_pend[k] = 1'b1;
      check($sformatf("rand_irq_%0d", it), {31'd0, irq_o}, {31'd0, model_irq()});
      rd_check($sformatf("rand_pending_%0d", it), 32'h080, 32'({m_pend, 1'b0}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
